ripple_count_sampler: RTL and testbench

- Consumer end of the low-power ripple counter. Takes the counter's free-running, asynchronously rippling count bus into the system `clk` domain.
- Accepts a value only after it has been stable for a programmable number of samples, which rejects ripple glitches.
- Converts each accepted change into a delta event (valid/ready) and a saturating running total for power-monitor logic.

---
 rtl/rcs_pkg.sv | 17 +
 rtl/rcs_bit_sync.sv | 23 ++
 rtl/ripple_count_sampler.sv | 158 +++++++++++++++
 tb/tb_ripple_count_sampler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rcs_pkg.sv
// rtl/rcs_pkg.sv - shared types and constants for the ripple count sampler
package rcs_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    PRIME    = 2'd1,
    TRACK    = 2'd2
  } rcs_state_e;

  // All-ones value of a w-bit field (w <= 64), used as a saturation ceiling.
  function automatic logic [63:0] rcs_sat_max(input int unsigned w);
    logic [63:0] ones;
    ones = '1;
    return (w >= 64) ? ones : (ones >> (64 - w));
  endfunction

endpackage

// File: rtl/rcs_bit_sync.sv
// rtl/rcs_bit_sync.sv - multi-flop synchronizer for one asynchronous input bit
module rcs_bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ripple_count_sampler.sv
// rtl/ripple_count_sampler.sv - qualifies a rippling count bus and emits delta events and a running total
module ripple_count_sampler
  import rcs_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CNT  = 2,
  parameter int unsigned ACC_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] stable_val,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_delta,
  output logic             evt_sat,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf
);

  localparam int unsigned RUN_W = (STABLE_CNT > 2) ? $clog2(STABLE_CNT) : 1;
  localparam logic [RUN_W-1:0] RUN_TOP  = RUN_W'(STABLE_CNT - 1);
  localparam logic [RUN_W-1:0] RUN_QUAL = RUN_W'(STABLE_CNT - 2);
  localparam logic [WIDTH-1:0] DELTA_MAX = WIDTH'(rcs_sat_max(WIDTH));
  localparam logic [ACC_W-1:0] ACC_MAX   = ACC_W'(rcs_sat_max(ACC_W));

  logic [WIDTH-1:0] samp, prev_samp_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic             same, qual;
  rcs_state_e       state_q, state_d;
  logic [WIDTH-1:0] last_val_q, last_val_d, stable_q, stable_d;
  logic [WIDTH-1:0] delta, evt_delta_q, evt_delta_d;
  logic             new_evt, xfer;
  logic             evt_valid_q, evt_valid_d, evt_sat_q, evt_sat_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [WIDTH:0]   evt_sum;
  logic [ACC_W:0]   acc_sum;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    rcs_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d_i  (cnt_in[i]),
      .q_o  (samp[i])
    );
  end

  // Run length saturates so qual fires exactly once per stable stretch.
  always_comb begin
    same  = (samp == prev_samp_q);
    run_d = '0;
    if (same) run_d = (run_q == RUN_TOP) ? run_q : run_q + 1'b1;
    qual  = same && (run_q == RUN_QUAL);
  end

  always_comb begin
    state_d    = state_q;
    last_val_d = last_val_q;
    stable_d   = stable_q;
    new_evt    = 1'b0;
    delta      = samp - last_val_q;
    case (state_q)
      DISABLED: if (enable) state_d = PRIME;
      PRIME: if (qual) begin
        last_val_d = samp;
        stable_d   = samp;
        state_d    = TRACK;
      end
      TRACK: if (qual && (samp != last_val_q)) begin
        last_val_d = samp;
        stable_d   = samp;
        new_evt    = 1'b1;
      end
      default: state_d = DISABLED;
    endcase
    if (!enable || clear) begin
      last_val_d = last_val_q;
      stable_d   = stable_q;
      new_evt    = 1'b0;
      state_d    = (clear && enable) ? PRIME : DISABLED;
    end
  end

  always_comb begin
    xfer        = evt_valid_q && evt_ready;
    evt_sum     = {1'b0, evt_delta_q} + {1'b0, delta};
    acc_sum     = {1'b0, acc_q} + (ACC_W+1)'(delta);
    evt_valid_d = evt_valid_q;
    evt_delta_d = evt_delta_q;
    evt_sat_d   = evt_sat_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    if (clear) begin
      evt_valid_d = 1'b0;
      evt_delta_d = '0;
      evt_sat_d   = 1'b0;
      acc_d       = '0;
      acc_ovf_d   = 1'b0;
    end else if (new_evt) begin
      if (acc_sum[ACC_W]) begin
        acc_d     = ACC_MAX;
        acc_ovf_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
      // A still-pending event absorbs the new delta instead of being lost.
      if (!evt_valid_q || xfer) begin
        evt_valid_d = 1'b1;
        evt_delta_d = delta;
      end else if (evt_sum[WIDTH]) begin
        evt_delta_d = DELTA_MAX;
        evt_sat_d   = 1'b1;
      end else begin
        evt_delta_d = evt_sum[WIDTH-1:0];
      end
    end else if (xfer) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_samp_q <= '0;
      run_q       <= '0;
      state_q     <= DISABLED;
      last_val_q  <= '0;
      stable_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_delta_q <= '0;
      evt_sat_q   <= 1'b0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
    end else begin
      prev_samp_q <= samp;
      run_q       <= run_d;
      state_q     <= state_d;
      last_val_q  <= last_val_d;
      stable_q    <= stable_d;
      evt_valid_q <= evt_valid_d;
      evt_delta_q <= evt_delta_d;
      evt_sat_q   <= evt_sat_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign stable_val = stable_q;
  assign evt_valid  = evt_valid_q;
  assign evt_delta  = evt_delta_q;
  assign evt_sat    = evt_sat_q;
  assign acc_out    = acc_q;
  assign acc_ovf    = acc_ovf_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb/tb_ripple_count_sampler.sv - directed vector bench for ripple_count_sampler
module tb_ripple_count_sampler;

  logic        clk = 1'b0;
  logic        rstn, enable, clear, evt_ready;
  logic [3:0]  cnt_in;
  logic [3:0]  stable_val, evt_delta, stable_val_s, evt_delta_s;
  logic        evt_valid, evt_sat, acc_ovf, evt_valid_s, evt_sat_s, acc_ovf_s;
  logic [15:0] acc_out;
  logic [4:0]  acc_out_s;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  ripple_count_sampler #(.WIDTH(4), .SYNC_STAGES(2), .STABLE_CNT(2), .ACC_W(16)) dut (
    .clk(clk), .rstn(rstn), .cnt_in(cnt_in), .enable(enable), .clear(clear),
    .stable_val(stable_val), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_delta(evt_delta), .evt_sat(evt_sat), .acc_out(acc_out), .acc_ovf(acc_ovf)
  );

  // Narrow accumulator copy sees identical stimulus to exercise acc saturation.
  ripple_count_sampler #(.WIDTH(4), .SYNC_STAGES(2), .STABLE_CNT(2), .ACC_W(5)) dut_s (
    .clk(clk), .rstn(rstn), .cnt_in(cnt_in), .enable(enable), .clear(clear),
    .stable_val(stable_val_s), .evt_valid(evt_valid_s), .evt_ready(evt_ready),
    .evt_delta(evt_delta_s), .evt_sat(evt_sat_s), .acc_out(acc_out_s), .acc_ovf(acc_ovf_s)
  );

  typedef struct {
    logic [3:0]  cnt;
    logic        rdy;
    logic        v;
    logic [3:0]  d;
    logic        s;
    logic [3:0]  st;
    logic [15:0] acc;
    logic [4:0]  accs;
    logic        ovfs;
  } vec_t;

  vec_t tbl [12];
  logic [3:0] cur_stable;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_vec(input int i);
    cnt_in    = tbl[i].cnt;
    evt_ready = tbl[i].rdy;
    step(3);
    chk($sformatf("v%0d_early_stable", i), 32'(stable_val), 32'(cur_stable));
    step(1);
    chk($sformatf("v%0d_valid", i), 32'(evt_valid), 32'(tbl[i].v));
    if (tbl[i].v) chk($sformatf("v%0d_delta", i), 32'(evt_delta), 32'(tbl[i].d));
    chk($sformatf("v%0d_sat", i), 32'(evt_sat), 32'(tbl[i].s));
    chk($sformatf("v%0d_stable", i), 32'(stable_val), 32'(tbl[i].st));
    chk($sformatf("v%0d_acc", i), 32'(acc_out), 32'(tbl[i].acc));
    chk($sformatf("v%0d_acc_s", i), 32'(acc_out_s), 32'(tbl[i].accs));
    chk($sformatf("v%0d_ovf_s", i), 32'(acc_ovf_s), 32'(tbl[i].ovfs));
    cur_stable = tbl[i].st;
    step(2);
  endtask

  initial begin
    int pulses;
    logic [3:0] seen_d;
    //          cnt   rdy   v     d     s     st    acc     accs   ovfs
    tbl[0]  = '{4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 16'd0,  5'd0,  1'b0};
    tbl[1]  = '{4'd7, 1'b1, 1'b1, 4'd4, 1'b0, 4'd7, 16'd4,  5'd4,  1'b0};
    tbl[2]  = '{4'd0, 1'b1, 1'b1, 4'd7, 1'b0, 4'd0, 16'd13, 5'd13, 1'b0};
    tbl[3]  = '{4'd4, 1'b0, 1'b1, 4'd4, 1'b0, 4'd4, 16'd17, 5'd17, 1'b0};
    tbl[4]  = '{4'd10,1'b0, 1'b1, 4'd10,1'b0, 4'd10,16'd23, 5'd23, 1'b0};
    tbl[5]  = '{4'd15,1'b0, 1'b1, 4'd15,1'b0, 4'd15,16'd28, 5'd28, 1'b0};
    tbl[6]  = '{4'd3, 1'b0, 1'b1, 4'd15,1'b1, 4'd3, 16'd32, 5'd31, 1'b1};
    tbl[7]  = '{4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 16'd0,  5'd0,  1'b0};
    tbl[8]  = '{4'd15,1'b1, 1'b1, 4'd15,1'b0, 4'd15,16'd15, 5'd15, 1'b0};
    tbl[9]  = '{4'd14,1'b1, 1'b1, 4'd15,1'b0, 4'd14,16'd30, 5'd30, 1'b0};
    tbl[10] = '{4'd1, 1'b1, 1'b1, 4'd3, 1'b0, 4'd1, 16'd33, 5'd31, 1'b1};
    tbl[11] = '{4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 4'd2, 16'd0,  5'd0,  1'b0};

    rstn = 1'b0; enable = 1'b0; clear = 1'b0; evt_ready = 1'b0; cnt_in = 4'd0;
    cur_stable = 4'd0;
    step(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_stable", 32'(stable_val), 32'd0);
    chk("rst_acc", 32'(acc_out), 32'd0);
    chk("rst_sat_ovf", 32'({evt_sat, acc_ovf}), 32'd0);

    rstn = 1'b1; enable = 1'b1; evt_ready = 1'b1;
    step(4);
    chk("idle_valid", 32'(evt_valid), 32'd0);
    chk("idle_stable", 32'(stable_val), 32'd0);
    chk("idle_acc", 32'(acc_out), 32'd0);

    for (int i = 0; i <= 1; i++) run_vec(i);

    // Glitching bus must never qualify; settling on 9 gives one event of 9-7.
    for (int i = 0; i < 10; i++) begin
      cnt_in = (i % 2 == 1) ? 4'd6 : 4'd5;
      step(1);
      chk("toggle_no_evt", 32'(evt_valid), 32'd0);
    end
    cnt_in = 4'd9;
    pulses = 0; seen_d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (evt_valid) begin pulses++; seen_d = evt_delta; end
    end
    chk("settle_pulses", 32'(pulses), 32'd1);
    chk("settle_delta", 32'(seen_d), 32'd2);
    chk("settle_acc", 32'(acc_out), 32'd6);
    cur_stable = 4'd9;

    for (int i = 2; i <= 6; i++) run_vec(i);

    chk("hold_valid", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    step(1);
    chk("xfer_valid", 32'(evt_valid), 32'd0);
    step(3);
    chk("xfer_once", 32'(evt_valid), 32'd0);
    chk("sat_sticky", 32'(evt_sat), 32'd1);

    clear = 1'b1; step(1); clear = 1'b0;
    chk("clr_acc", 32'(acc_out), 32'd0);
    chk("clr_acc_s", 32'(acc_out_s), 32'd0);
    chk("clr_ovf_s", 32'(acc_ovf_s), 32'd0);
    chk("clr_sat", 32'(evt_sat), 32'd0);
    chk("clr_valid", 32'(evt_valid), 32'd0);
    chk("clr_keeps_stable", 32'(stable_val), 32'd3);

    for (int i = 7; i <= 10; i++) run_vec(i);
    chk("wide_no_ovf", 32'(acc_ovf), 32'd0);

    clear = 1'b1; step(1); clear = 1'b0;
    chk("clr2_acc_s", 32'(acc_out_s), 32'd0);
    chk("clr2_ovf_s", 32'(acc_ovf_s), 32'd0);
    run_vec(11);

    enable = 1'b0;
    cnt_in = 4'd5;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("dis_no_evt", 32'(evt_valid), 32'd0);
    end
    chk("dis_stable_hold", 32'(stable_val), 32'd2);
    cnt_in = 4'd8;
    step(2);
    enable = 1'b1;
    step(2);
    chk("reprime_stable", 32'(stable_val), 32'd8);
    chk("reprime_no_evt", 32'(evt_valid), 32'd0);
    chk("reprime_acc", 32'(acc_out), 32'd0);
    step(2);
    cnt_in = 4'd9;
    step(4);
    chk("after_prime_valid", 32'(evt_valid), 32'd1);
    chk("after_prime_delta", 32'(evt_delta), 32'd1);
    chk("after_prime_acc", 32'(acc_out), 32'd1);
    step(2);

    evt_ready = 1'b0;
    cnt_in = 4'd12;
    step(4);
    chk("pend_valid", 32'(evt_valid), 32'd1);
    chk("pend_delta", 32'(evt_delta), 32'd3);
    chk("pend_acc", 32'(acc_out), 32'd4);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(evt_valid), 32'd0);
    chk("mid_rst_acc", 32'(acc_out), 32'd0);
    chk("mid_rst_stable", 32'(stable_val), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
